// File: rtl/decode_stage.sv
// decode_stage: 16-bit instruction decoder feeding the register file and ALU.
//   The decoded output is registered, with a valid/ready handshake and a
//   2-entry (main + skid) buffer so the stage runs at full throughput under backpressure.
// Ports:
//   clk, reset (async, active-high), flush (sync, discards everything held and incoming)
//   in_valid/in_ready/instr   upstream handshake and instruction word
//   out_valid/out_ready       downstream handshake
//   alu_op, rd, rs, imm, use_imm, wr_en, illegal   decoded fields
module decode_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            alu_op,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [DATA_W-1:0]     imm,
  output logic                  use_imm,
  output logic                  wr_en,
  output logic                  illegal
);
  localparam int PW = 8 + 2 * REG_ADDR_W + DATA_W + 3;
  logic [3:0]        w_hi;
  logic [3:0]        w_ext;
  logic [7:0]        w_op;
  logic [DATA_W-1:0] w_imm;
  logic              w_use_imm;
  logic              w_wr_en;
  logic              w_illegal;
  logic              w_accept;
  logic [PW-1:0]     w_dec;
  logic [PW-1:0]     r_main;
  logic [PW-1:0]     r_skid;
  logic              r_mvalid;
  logic              r_svalid;
  assign w_hi  = instr[15:12];
  assign w_ext = instr[7:4];
  always_comb begin
    w_op      = '0;
    w_imm     = '0;
    w_use_imm = 1'b0;
    w_wr_en   = 1'b0;
    w_illegal = 1'b0;
    case (w_hi)
      4'h0:
        if (w_ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hE}) begin
          w_op    = {4'h0, w_ext};
          w_wr_en = w_ext != 4'hB;
        end else
          w_illegal = 1'b1;
      4'h8:
        if (w_ext == 4'h4 || w_ext == 4'h6) begin
          w_op    = {4'h8, w_ext};
          w_wr_en = 1'b1;
        end else if (w_ext[3:1] == 3'b000) begin
          // LSHI: instr[4] is both the low ext bit and the sign of the 5-bit shift amount
          w_op      = 8'h84;
          w_imm     = DATA_W'($signed(instr[4:0]));
          w_use_imm = 1'b1;
          w_wr_en   = 1'b1;
        end else
          w_illegal = 1'b1;
      4'h1, 4'h2, 4'h3, 4'hD: begin
        w_op      = {4'h0, w_hi};
        w_imm     = DATA_W'(instr[7:0]);
        w_use_imm = 1'b1;
        w_wr_en   = 1'b1;
      end
      4'h5, 4'h9, 4'hB, 4'hE: begin
        w_op      = {4'h0, w_hi};
        w_imm     = DATA_W'($signed(instr[7:0]));
        w_use_imm = 1'b1;
        w_wr_en   = w_hi != 4'hB;
      end
      4'hF: begin
        w_op      = 8'h0D;
        w_imm     = DATA_W'({instr[7:0], 8'h00});
        w_use_imm = 1'b1;
        w_wr_en   = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end
  assign w_dec    = {w_illegal, w_wr_en, w_use_imm, w_imm,
                     REG_ADDR_W'(instr[3:0]), REG_ADDR_W'(instr[11:8]), w_op};
  assign in_ready = ~r_svalid;
  assign w_accept = in_valid & in_ready & ~flush;
  // The skid entry only fills while main is stalled; since in_ready is low
  // whenever skid is full, skid drain and a new accept never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_mvalid <= 1'b0;
      r_svalid <= 1'b0;
    end else if (flush) begin
      r_mvalid <= 1'b0;
      r_svalid <= 1'b0;
    end else if (!r_mvalid || out_ready) begin
      if (r_svalid) begin
        r_main   <= r_skid;
        r_mvalid <= 1'b1;
        r_svalid <= 1'b0;
      end else if (w_accept) begin
        r_main   <= w_dec;
        r_mvalid <= 1'b1;
      end else
        r_mvalid <= 1'b0;
    end else if (w_accept) begin
      r_skid   <= w_dec;
      r_svalid <= 1'b1;
    end
  end
  assign out_valid = r_mvalid;
  assign {illegal, wr_en, use_imm, imm, rs, rd, alu_op} = r_main;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  alu_op;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [15:0] imm;
  logic        use_imm;
  logic        wr_en;
  logic        illegal;
  int          n_tests = 0;
  int          n_fail  = 0;
  decode_stage #(.DATA_W(16), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .rd(rd), .rs(rs), .imm(imm), .use_imm(use_imm), .wr_en(wr_en), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_dec(input string tag, input logic [7:0] op, input logic [4:0] e_rd,
                           input logic [4:0] e_rs, input logic [15:0] e_imm,
                           input logic e_use, input logic e_wr, input logic e_ill);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".op"}, alu_op, op);
    check({tag, ".rd"}, rd, e_rd);
    check({tag, ".rs"}, rs, e_rs);
    check({tag, ".imm"}, imm, e_imm);
    check({tag, ".use_imm"}, use_imm, e_use);
    check({tag, ".wr_en"}, wr_en, e_wr);
    check({tag, ".illegal"}, illegal, e_ill);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    instr    = w;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
    repeat (2) tick();
    check("rst.valid", out_valid, 0);
    check("rst.ready", in_ready, 1);
    check("rst.op", alu_op, 0);
    check("rst.imm", imm, 0);
    reset = 1'b0;
    tick();
    send(16'h53FE); check_dec("addi", 8'h05, 5'd3, 5'hE, 16'hFFFE, 1, 1, 0);
    tick();
    check("idle.valid", out_valid, 0);
    send(16'h1280); check_dec("andi", 8'h01, 5'd2, 5'h0, 16'h0080, 1, 1, 0);
    send(16'hF1AB); check_dec("lui", 8'h0D, 5'd1, 5'hB, 16'hAB00, 1, 1, 0);
    send(16'h04B5); check_dec("cmp", 8'h0B, 5'd4, 5'h5, 16'h0000, 0, 0, 0);
    send(16'h0070); check_dec("ill0", 8'h00, 5'd0, 5'h0, 16'h0000, 0, 0, 1);
    send(16'h8A1F); check_dec("lshi", 8'h84, 5'hA, 5'hF, 16'hFFFF, 1, 1, 0);
    send(16'h8346); check_dec("lsh", 8'h84, 5'd3, 5'h6, 16'h0000, 0, 1, 0);
    send(16'h9C07); check_dec("subi", 8'h09, 5'hC, 5'h7, 16'h0007, 1, 1, 0);
    send(16'h4123); check_dec("ill4", 8'h00, 5'd1, 5'h3, 16'h0000, 0, 0, 1);
    send(16'h0BE1); check_dec("mul", 8'h0E, 5'hB, 5'h1, 16'h0000, 0, 1, 0);
    send(16'hBAF0); check_dec("cmpi", 8'h0B, 5'hA, 5'h0, 16'hFFF0, 1, 0, 0);
    tick();
    // backpressure: A=1111 B=2222 C=3333
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h1111;
    tick();
    check("bp.a_ready", in_ready, 1);
    instr = 16'h2222;
    tick();
    check("bp.skid_full", in_ready, 0);
    check_dec("bp.holdA1", 8'h01, 5'd1, 5'h1, 16'h0011, 1, 1, 0);
    instr = 16'h3333;
    tick();
    tick();
    check("bp.still_full", in_ready, 0);
    check_dec("bp.holdA2", 8'h01, 5'd1, 5'h1, 16'h0011, 1, 1, 0);
    out_ready = 1'b1;
    tick();
    check_dec("bp.B", 8'h02, 5'd2, 5'h2, 16'h0022, 1, 1, 0);
    check("bp.ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_dec("bp.C", 8'h03, 5'd3, 5'h3, 16'h0033, 1, 1, 0);
    tick();
    check("bp.drained", out_valid, 0);
    // flush with main and skid full and a valid input present
    out_ready = 1'b0;
    send(16'h1111);
    send(16'h2222);
    check("fl.full", in_ready, 0);
    in_valid = 1'b1; instr = 16'h3333; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.valid", out_valid, 0);
    check("fl.ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("fl.nothing", out_valid, 0);
    send(16'h5001); check_dec("fl.next", 8'h05, 5'd0, 5'h1, 16'h0001, 1, 1, 0);
    tick();
    check("fl.empty", out_valid, 0);
    // reset mid-stall
    out_ready = 1'b0;
    send(16'h1111);
    send(16'h2222);
    #2 reset = 1'b1;
    #1;
    check("rs.valid", out_valid, 0);
    check("rs.ready", in_ready, 1);
    check("rs.op", alu_op, 0);
    check("rs.imm", imm, 0);
    check("rs.rd", rd, 0);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    send(16'h0BE1); check_dec("rs.first", 8'h0E, 5'hB, 5'h1, 16'h0000, 0, 1, 0);
    tick();
    check("rs.no_ghost", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
